// File: rtl/mu_alu_requester.sv
// mu_alu_requester: issues one command at a time to a multi-cycle mu-ALU, with wait timeout
// and illegal-opcode handling. Define MU_REQ_ACCUM_EN to build the saturating mu_total accumulator.
module mu_alu_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic [2:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_valid,
  input  logic [31:0] alu_result,
  input  logic        alu_ready,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_overflow,
  output logic        rsp_timeout,
  output logic        rsp_illegal,
  output logic [15:0] ops_done,
  output logic [31:0] mu_total
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [2:0] OP_INFO_GAIN = 3'd5;
  localparam logic [7:0] LAST_WAIT    = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        alu_valid_q, alu_valid_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_overflow_q, rsp_overflow_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        rsp_illegal_q, rsp_illegal_d;
  logic [15:0] ops_done_q, ops_done_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  logic accept;
  logic rsp_fire;

  assign accept   = cmd_valid && cmd_ready_q;
  assign rsp_fire = (state_q == RESP) && rsp_ready;

  always_comb begin
    // NOTE: every _d gets a hold/default value first so no path through the case infers a latch.
    state_d        = state_q;
    cmd_ready_d    = 1'b0;
    alu_valid_d    = 1'b0;
    alu_op_d       = alu_op_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_result_d   = rsp_result_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_timeout_d  = rsp_timeout_q;
    rsp_illegal_d  = rsp_illegal_q;
    ops_done_d     = ops_done_q;
    wait_cnt_d     = wait_cnt_q;

    unique case (state_q)
      IDLE: begin
        // cmd_ready is registered, so it stays low for the first IDLE cycle after RESP or reset.
        cmd_ready_d = !accept;
        if (accept) begin
          alu_op_d = cmd_op;
          alu_a_d  = cmd_a;
          alu_b_d  = cmd_b;
          if (cmd_op[2] && cmd_op[1]) begin
            state_d        = RESP;
            rsp_valid_d    = 1'b1;
            rsp_result_d   = '0;
            rsp_overflow_d = 1'b0;
            rsp_timeout_d  = 1'b0;
            rsp_illegal_d  = 1'b1;
          end else begin
            state_d     = ISSUE;
            alu_valid_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
      end
      WAIT: begin
        if (alu_ready) begin
          state_d        = RESP;
          rsp_valid_d    = 1'b1;
          rsp_result_d   = alu_result;
          rsp_overflow_d = alu_overflow;
          rsp_timeout_d  = 1'b0;
          rsp_illegal_d  = 1'b0;
        end else if (wait_cnt_q == LAST_WAIT) begin
          state_d        = RESP;
          rsp_valid_d    = 1'b1;
          rsp_result_d   = '0;
          rsp_overflow_d = 1'b0;
          rsp_timeout_d  = 1'b1;
          rsp_illegal_d  = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          ops_done_d  = ops_done_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
    if (rst) begin
      state_q        <= IDLE;
      cmd_ready_q    <= 1'b0;
      alu_valid_q    <= 1'b0;
      alu_op_q       <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      rsp_illegal_q  <= 1'b0;
      ops_done_q     <= '0;
      wait_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      cmd_ready_q    <= cmd_ready_d;
      alu_valid_q    <= alu_valid_d;
      alu_op_q       <= alu_op_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_timeout_q  <= rsp_timeout_d;
      rsp_illegal_q  <= rsp_illegal_d;
      ops_done_q     <= ops_done_d;
      wait_cnt_q     <= wait_cnt_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign alu_valid    = alu_valid_q;
  assign alu_op       = alu_op_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign rsp_illegal  = rsp_illegal_q;
  assign ops_done     = ops_done_q;

`ifdef MU_REQ_ACCUM_EN
  logic [31:0] mu_total_q, mu_total_d;
  logic [32:0] mu_sum;

  // Only clean INFO_GAIN results are charged; illegal ops latch 6/7 and never match.
  always_comb begin
    mu_sum     = {1'b0, mu_total_q} + {1'b0, rsp_result_q};
    mu_total_d = mu_total_q;
    if (rsp_fire && (alu_op_q == OP_INFO_GAIN) && !rsp_overflow_q && !rsp_timeout_q)
      mu_total_d = mu_sum[32] ? '1 : mu_sum[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) mu_total_q <= '0;
    else     mu_total_q <= mu_total_d;
  end

  assign mu_total = mu_total_q;
`else
  logic unused_rsp_fire;
  assign unused_rsp_fire = rsp_fire;
  assign mu_total        = '0;
`endif

endmodule

// File: tb/tb_mu_alu_requester.sv
// Self-checking bench for mu_alu_requester: transaction-level timing model plus an in-bench mu-ALU,
// directed cases and randomized traffic. Honours MU_REQ_ACCUM_EN for the mu_total expectations.
module tb_mu_alu_requester;

  localparam int T = 8;

`ifdef MU_REQ_ACCUM_EN
  localparam logic [31:0] MU_AFTER_TWO = 32'h00040000;
  localparam logic [31:0] MU_SAT       = 32'hFFFFFFFF;
`else
  localparam logic [31:0] MU_AFTER_TWO = 32'h0;
  localparam logic [31:0] MU_SAT       = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic        alu_valid;
  logic [31:0] alu_result;
  logic        alu_ready, alu_overflow;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_overflow, rsp_timeout, rsp_illegal;
  logic [15:0] ops_done;
  logic [31:0] mu_total;

  mu_alu_requester #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_valid(alu_valid),
    .alu_result(alu_result), .alu_ready(alu_ready), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout), .rsp_illegal(rsp_illegal),
    .ops_done(ops_done), .mu_total(mu_total)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference state: last accepted command, delivered-response count, accumulated mu.
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b, m_mu;
  logic [15:0] m_ops;
  int          idle_age;

  // Expected outputs for the current cycle.
  logic        chk_en;
  logic        exp_cmd_ready, exp_alu_valid, exp_rsp_valid, exp_pay_chk;
  logic [2:0]  exp_alu_op;
  logic [31:0] exp_alu_a, exp_alu_b, exp_result, exp_mu;
  logic        exp_ovf, exp_to, exp_ill;
  logic [15:0] exp_ops;

  int          cyc = 0;
  int          issue_cyc, rsp_cyc, n_pulse;
  logic [31:0] cap_result;
  logic        cap_ovf, cap_to, cap_ill;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural mu-ALU: Q16.16 arithmetic, DIV by zero flags overflow, INFO_GAIN flags carry-out.
  function automatic void alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic o);
    logic signed [63:0] w;
    logic [32:0] s;
    r = '0; o = 1'b0; w = '0; s = '0;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: begin
        w = ($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b})) >>> 16;
        r = w[31:0];
      end
      3'd3: begin
        if (b == 32'd0) o = 1'b1;
        else begin
          w = $signed({{16{a[31]}}, a, 16'h0000}) / $signed({{32{b[31]}}, b});
          r = w[31:0];
        end
      end
      3'd5: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        o = s[32];
      end
      default: r = a ^ b;
    endcase
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] x, input logic [31:0] y);
    logic [32:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[32] ? 32'hFFFFFFFF : s[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_common();
    exp_alu_op  = m_op;
    exp_alu_a   = m_a;
    exp_alu_b   = m_b;
    exp_ops     = m_ops;
    exp_mu      = m_mu;
    exp_pay_chk = 1'b0;
  endtask

  task automatic noise();
    alu_ready    = 1'($urandom);
    alu_result   = $urandom;
    alu_overflow = 1'($urandom);
  endtask

  task automatic model_reset();
    m_op = '0; m_a = '0; m_b = '0; m_mu = '0; m_ops = '0;
    idle_age = 0;
  endtask

  // Single compare process: every cycle, DUT outputs against the model's expectations.
  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      check("cmd_ready", 32'(cmd_ready), 32'(exp_cmd_ready));
      check("alu_valid", 32'(alu_valid), 32'(exp_alu_valid));
      check("alu_op",    32'(alu_op),    32'(exp_alu_op));
      check("alu_a",     alu_a,          exp_alu_a);
      check("alu_b",     alu_b,          exp_alu_b);
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
      check("ops_done",  32'(ops_done),  32'(exp_ops));
      check("mu_total",  mu_total,       exp_mu);
      if (exp_rsp_valid || exp_pay_chk) begin
        check("rsp_result",   rsp_result,         exp_result);
        check("rsp_overflow", 32'(rsp_overflow),  32'(exp_ovf));
        check("rsp_timeout",  32'(rsp_timeout),   32'(exp_to));
        check("rsp_illegal",  32'(rsp_illegal),   32'(exp_ill));
      end
      if (alu_valid) begin
        n_pulse++;
        issue_cyc = cyc;
      end
      if (rsp_valid && rsp_cyc < 0) rsp_cyc = cyc;
      if (rsp_valid && rsp_ready) begin
        cap_result = rsp_result;
        cap_ovf    = rsp_overflow;
        cap_to     = rsp_timeout;
        cap_ill    = rsp_illegal;
      end
    end
  end

  // One command: gap idle cycles, then present it; ALU answers lat cycles after alu_valid,
  // downstream stalls hold cycles; abort_c > 0 pulses rst in that post-accept cycle.
  task automatic run_txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int hold, input int gap, input int abort_c);
    logic        legal, acc, hs, o;
    logic [31:0] r;
    int          rsp_c;
    legal = (op < 3'd6);
    alu_model(op, a, b, r, o);
    for (int i = 0; i < gap; i++) begin
      cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_a = $urandom; cmd_b = $urandom;
      noise();
      rsp_ready = 1'($urandom);
      set_common();
      exp_cmd_ready = (idle_age >= 1); exp_alu_valid = 1'b0; exp_rsp_valid = 1'b0;
      tick();
      idle_age++;
    end
    n_pulse = 0; issue_cyc = -1; rsp_cyc = -1;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    acc = 1'b0;
    while (!acc) begin
      noise();
      rsp_ready = 1'($urandom);
      set_common();
      exp_cmd_ready = (idle_age >= 1); exp_alu_valid = 1'b0; exp_rsp_valid = 1'b0;
      acc = (idle_age >= 1);
      tick();
      idle_age++;
    end
    m_op = op; m_a = a; m_b = b;
    if (!legal) begin
      rsp_c = 1; exp_result = '0; exp_ovf = 1'b0; exp_to = 1'b0; exp_ill = 1'b1;
    end else if (lat <= T) begin
      rsp_c = 2 + lat; exp_result = r; exp_ovf = o; exp_to = 1'b0; exp_ill = 1'b0;
    end else begin
      rsp_c = 2 + T; exp_result = '0; exp_ovf = 1'b0; exp_to = 1'b1; exp_ill = 1'b0;
    end
    hs = 1'b0;
    for (int c = 1; !hs; c++) begin
      cmd_valid = 1'($urandom); cmd_op = 3'($urandom); cmd_a = $urandom; cmd_b = $urandom;
      if (legal && c == 1 + lat) begin
        alu_ready = 1'b1; alu_result = r; alu_overflow = o;
      end else if (legal && c >= 2 && c < rsp_c) begin
        alu_ready = 1'b0; alu_result = $urandom; alu_overflow = 1'($urandom);
      end else begin
        noise();
      end
      if (c >= rsp_c + hold)  rsp_ready = 1'b1;
      else if (c >= rsp_c)    rsp_ready = 1'b0;
      else                    rsp_ready = 1'($urandom);
      set_common();
      exp_cmd_ready = 1'b0;
      exp_alu_valid = legal && (c == 1);
      exp_rsp_valid = (c >= rsp_c);
      if (c == abort_c) begin
        rst = 1'b1;
        tick();
        rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; alu_ready = 1'b0;
        model_reset();
        return;
      end
      hs = (c >= rsp_c + hold);
      tick();
    end
    m_ops++;
`ifdef MU_REQ_ACCUM_EN
    if (op == 3'd5 && !exp_ovf && !exp_to) m_mu = sat_add(m_mu, exp_result);
`endif
    cmd_valid = 1'b0; rsp_ready = 1'b0; alu_ready = 1'b0;
    idle_age = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; chk_en = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    alu_ready = 1'b0; alu_result = '0; alu_overflow = 1'b0; rsp_ready = 1'b0;
    model_reset();
    exp_cmd_ready = 1'b0; exp_alu_valid = 1'b0; exp_rsp_valid = 1'b0;
    exp_result = '0; exp_ovf = 1'b0; exp_to = 1'b0; exp_ill = 1'b0;
    set_common();
    tick();
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      noise();
      set_common();
      exp_pay_chk = 1'b1;
      exp_result = '0; exp_ovf = 1'b0; exp_to = 1'b0; exp_ill = 1'b0;
      tick();
    end
    rst = 1'b0; alu_ready = 1'b0;
    idle_age = 0;

    // ADD with ALU ready two cycles after alu_valid.
    run_txn(3'd0, 32'h00010000, 32'h00010000, 2, 0, 1, 0);
    check("add_result",  cap_result, 32'h00020000);
    check("add_flags",   32'({cap_ovf, cap_to, cap_ill}), 32'h0);
    check("add_ops",     32'(ops_done), 32'd1);
    check("add_latency", 32'(rsp_cyc - issue_cyc), 32'd3);

    // DIV by zero: overflow reported, exactly one issue strobe.
    run_txn(3'd3, 32'h00010000, 32'h0, 1, 1, 0, 0);
    check("div0_ovf",    32'(cap_ovf), 32'd1);
    check("div0_pulses", 32'(n_pulse), 32'd1);

    // MUL never answered: timeout after T WAIT cycles, late ready ignored.
    run_txn(3'd2, 32'h00020000, 32'h00030000, T + 3, 4, 0, 0);
    check("to_flag",     32'(cap_to), 32'd1);
    check("to_result",   cap_result, 32'h0);
    check("to_wait_cyc", 32'(rsp_cyc - issue_cyc - 1), 32'(T));

    // Illegal opcode.
    run_txn(3'd7, 32'h12345678, 32'h9ABCDEF0, 1, 0, 2, 0);
    check("ill_flag",   32'(cap_ill), 32'd1);
    check("ill_pulses", 32'(n_pulse), 32'd0);

    // SUB with downstream stall.
    run_txn(3'd1, 32'h00030000, 32'h00018000, 1, 5, 0, 0);
    check("sub_result", cap_result, 32'h00018000);
    check("sub_ops",    32'(ops_done), 32'd5);

    // Ready on the very last WAIT cycle still wins over timeout.
    run_txn(3'd0, 32'h00000005, 32'h00000007, T, 0, 0, 0);
    check("edge_to",     32'(cap_to), 32'd0);
    check("edge_result", cap_result, 32'h0000000C);

    // INFO_GAIN accounting and saturation.
    run_txn(3'd5, 32'h00020000, 32'h0, 1, 0, 0, 0);
    run_txn(3'd5, 32'h00020000, 32'h0, 3, 1, 1, 0);
    check("mu_two_dut",   mu_total, MU_AFTER_TWO);
    check("mu_two_model", m_mu, MU_AFTER_TWO);
    run_txn(3'd5, 32'hF0000000, 32'h0, 2, 0, 0, 0);
    run_txn(3'd5, 32'hF0000000, 32'h0, 2, 0, 0, 0);
    check("mu_sat", mu_total, MU_SAT);

    // Reset in the middle of WAIT: no response, counters cleared.
    run_txn(3'd2, 32'h00010000, 32'h00010000, T + 5, 0, 1, 4);
    check("abort_norsp", 32'(rsp_cyc < 0), 32'd1);
    check("abort_ops",   32'(ops_done), 32'd0);
    check("abort_mu",    mu_total, 32'h0);

    for (int i = 0; i < 40; i++) begin
      run_txn(3'($urandom), $urandom, $urandom, int'($urandom_range(1, T + 2)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 0);
    end
    run_txn(3'd4, 32'h0000FFFF, 32'h0000F0F0, 1, 0, 3, 0);
    check("op4_result", cap_result, 32'h00000F0F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mu_alu_requester.md
MU_ALU_REQUESTER -- requirements
Module: mu_alu_requester

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, the maximum number of WAIT cycles before a request is abandoned (legal range 1..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  the upstream request is present.
REQ-005 SHALL have port cmd_ready  output  1  the block accepts a request this cycle.
REQ-006 SHALL have port cmd_op  input  3  the μ-ALU opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 5 INFO_GAIN; 4 is legal; 6 and 7 are illegal.
REQ-007 SHALL have ports cmd_a and cmd_b  input  32  the operands (Q16.16, or integers for INFO_GAIN).
REQ-008 SHALL have ports alu_op  output  3, alu_a  output  32, alu_b  output  32  the operands driven to the μ-ALU.
REQ-009 SHALL have port alu_valid  output  1  a one-cycle issue strobe to the μ-ALU.
REQ-010 SHALL have ports alu_result  input  32, alu_ready  input  1, alu_overflow  input  1  the μ-ALU completion inputs.
REQ-011 SHALL have ports rsp_valid  output  1, rsp_ready  input  1  the downstream response handshake.
REQ-012 SHALL have ports rsp_result  output  32, rsp_overflow  output  1, rsp_timeout  output  1, rsp_illegal  output  1  the response payload.
REQ-013 SHALL have port ops_done  output  16  the count of responses delivered (wraps modulo 2^16).
REQ-014 SHALL have port mu_total  output  32  the accumulated information-gain μ-cost.

Function
REQ-015 SHALL implement the states IDLE, ISSUE, WAIT and RESP.
REQ-016 SHALL assert cmd_ready only in IDLE; cmd_valid && cmd_ready SHALL latch cmd_op, cmd_a and cmd_b into alu_op, alu_a and alu_b.
REQ-017 SHALL, on an accepted legal op, go IDLE→ISSUE; alu_valid SHALL be 1 for exactly the ISSUE cycle, then ISSUE→WAIT.
REQ-018 SHALL, on an accepted illegal op (6 or 7), go IDLE→RESP with rsp_illegal=1 and rsp_result=0, and SHALL NOT assert alu_valid.
REQ-019 SHALL hold alu_op, alu_a and alu_b stable from ISSUE until the exit from WAIT.
REQ-020 SHALL, in WAIT, on the first cycle with alu_ready=1, capture alu_result into rsp_result and alu_overflow into rsp_overflow, then go to RESP.
REQ-021 SHALL count WAIT cycles; if TIMEOUT_CYCLES cycles elapse with no alu_ready, go to RESP with rsp_timeout=1, rsp_result=0 and rsp_overflow=0.
REQ-022 SHALL ignore alu_ready in any state other than WAIT, including a late ready after a timeout.
REQ-023 SHALL set latency as follows: accept at cycle 0, alu_valid at cycle 1, alu_ready at the earliest at cycle 2, rsp_valid the cycle after alu_ready is sampled.
REQ-024 SHALL hold rsp_valid and the whole payload stable in RESP until rsp_ready=1, then increment ops_done and return to IDLE.
REQ-025 SHALL NOT accept a new command in the RESP→IDLE handoff cycle; cmd_ready rises on the following cycle.
REQ-026 SHALL clear all flags that do not apply to a given response, so at most one of rsp_timeout and rsp_illegal is 1.

Reset
REQ-027 SHALL, on rst, enter IDLE and drive cmd_ready=0 in the reset cycle, then 1 afterwards.
REQ-028 SHALL, on rst, clear alu_valid, rsp_valid, all rsp_* fields, alu_op, alu_a, alu_b, ops_done, mu_total and the timeout counter to 0.
REQ-029 SHALL, when rst is asserted mid-operation (ISSUE, WAIT or RESP), abandon the request without producing a response.

Configuration
REQ-030 SHALL compile μ-accounting in with macro MU_REQ_ACCUM_EN defined: on each RESP handshake for op 5 with rsp_overflow=0 and rsp_timeout=0, mu_total += rsp_result as unsigned.
REQ-031 SHALL, with MU_REQ_ACCUM_EN defined, saturate mu_total at 0xFFFFFFFF.
REQ-032 SHALL, with MU_REQ_ACCUM_EN undefined, tie mu_total to constant 0 with no accumulator register.

Verification
REQ-033 SHALL pass: ADD 0x00010000 + 0x00010000, ALU model ready 2 cycles after valid → rsp_result 0x00020000, flags 0, ops_done 1.
REQ-034 SHALL pass: DIV 0x00010000 / 0 with the model asserting overflow → rsp_overflow=1, single alu_valid pulse.
REQ-035 SHALL pass: MUL with alu_ready held 0, TIMEOUT_CYCLES=8 → rsp_valid 8 WAIT cycles after ISSUE, rsp_timeout=1; a late alu_ready is ignored.
REQ-036 SHALL pass: op 7 → rsp_illegal=1, alu_valid never asserted.
REQ-037 SHALL pass: SUB 0x00030000 − 0x00018000 with rsp_ready held 0 for 5 cycles → payload 0x00018000 stable, cmd_ready=0 throughout.
REQ-038 SHALL pass with MU_REQ_ACCUM_EN: two INFO_GAIN results of 0x00020000 → mu_total 0x00040000; a preload near the top saturates to 0xFFFFFFFF; rst mid-WAIT → no response, mu_total=0.
